// File: rtl/async_fifo_rd_engine.sv
// Read-side consumer engine for the async FIFO (read clock domain only).
// Drains a programmed number of words from a first-word-fall-through FIFO
// into a 2-entry skid buffer and presents them on a valid/ready stream.
// Reports busy, a done pulse, the word count and a sticky starvation timeout.
module async_fifo_rd_engine #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [DATA_WIDTH-1:0] rData,
  input  logic                  rEmpty,
  output logic                  rinc,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  words_read
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH,
    DONE
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntOne    = 1;
  localparam logic [31:0]          IdleLimit = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
  localparam bit                   TimeoutEn = (TIMEOUT != 0);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]  wordsRead_q, wordsRead_d;
  logic [31:0]           idleCnt_q, idleCnt_d;
  logic                  timeout_q, timeout_d;
  logic                  busy_q;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] buf0_q;
  logic [DATA_WIDTH-1:0] buf1_q;
  logic [1:0]            bufCnt_q;

  logic                  push;
  logic                  pop;

  // Pop the FIFO only when a word is there, the burst is not finished and the
  // skid buffer has room; m_ready deliberately plays no part here.
  assign push = (state_q == READ) && !rEmpty && (remaining_q != '0) &&
                (bufCnt_q != 2'd2) && !rrst;
  assign pop  = (bufCnt_q != 2'd0) && m_ready;

  assign rinc       = push;
  assign m_valid    = (bufCnt_q != 2'd0);
  assign m_data     = buf0_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign words_read = wordsRead_q;

  // Next-state and counter logic for the burst controller.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wordsRead_d = wordsRead_q;
    idleCnt_d   = idleCnt_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = burst_len;
          wordsRead_d = '0;
          timeout_d   = 1'b0;
          idleCnt_d   = '0;
          state_d     = (burst_len == '0) ? FLUSH : READ;
        end
      end
      READ: begin
        if (remaining_q == '0) begin
          state_d = FLUSH;
        end else if (push) begin
          remaining_d = remaining_q - CntOne;
          wordsRead_d = wordsRead_q + CntOne;
          idleCnt_d   = '0;
        end else if (rEmpty) begin
          idleCnt_d = idleCnt_q + 32'd1;
          if (TimeoutEn && (idleCnt_d >= IdleLimit)) begin
            timeout_d = 1'b1;
            state_d   = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (bufCnt_q == 2'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers; busy and done are registered from the next state.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      wordsRead_q <= '0;
      idleCnt_q   <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wordsRead_q <= wordsRead_d;
      idleCnt_q   <= idleCnt_d;
      timeout_q   <= timeout_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  // Two-entry in-order skid buffer; buf0_q is always the head presented downstream.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      bufCnt_q <= 2'd0;
      buf0_q   <= '0;
      buf1_q   <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (bufCnt_q == 2'd0) begin
            buf0_q <= rData;
          end else begin
            buf1_q <= rData;
          end
          bufCnt_q <= bufCnt_q + 2'd1;
        end
        2'b01: begin
          buf0_q   <= buf1_q;
          bufCnt_q <= bufCnt_q - 2'd1;
        end
        2'b11: begin
          if (bufCnt_q == 2'd1) begin
            buf0_q <= rData;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= rData;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
